// File: rtl/rgb_window_feeder.sv
// rgb_window_feeder: turns a raster-order RGB pixel stream into sliding
// 3x3x3 windows (valid convolution, stride 1) for the PE array. Two line
// buffers hold the previous two rows, and a 2-column shift register per row
// holds the older window columns. A single output register carries each
// window, and the whole pipeline stalls under downstream backpressure.
module rgb_window_feeder #(
    parameter int IMG_WIDTH  = 32,
    parameter int IMG_HEIGHT = 32,
    parameter int PIX_W      = 8
) (
    input  logic                 clk_i,
    input  logic                 rst_n,
    input  logic                 px_valid_i,
    output logic                 px_ready_o,
    input  logic [3*PIX_W-1:0]   px_data_i,
    output logic                 win_valid_o,
    input  logic                 win_ready_i,
    output logic [27*PIX_W-1:0]  win_data_o,
    output logic                 win_last_o,
    output logic                 frame_done_o
);

    localparam int COL_W = $clog2(IMG_WIDTH);
    localparam int ROW_W = $clog2(IMG_HEIGHT);
    localparam int PX_W  = 3 * PIX_W;
    localparam int CH_W  = 9 * PIX_W;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_RUN   = 2'd1;
    localparam logic [1:0] ST_FLUSH = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;

    logic [1:0]       state_reg;
    logic [COL_W-1:0] col_reg;
    logic [ROW_W-1:0] row_reg;

    // linebuf0 holds row r-1, linebuf1 holds row r-2 (relative to the pixel being accepted)
    logic [PX_W-1:0] linebuf0_mem [0:IMG_WIDTH-1];
    logic [PX_W-1:0] linebuf1_mem [0:IMG_WIDTH-1];

    // Older two window columns per row: index 0 is column c-2, index 1 is column c-1
    logic [PX_W-1:0] top_reg [0:1];
    logic [PX_W-1:0] mid_reg [0:1];
    logic [PX_W-1:0] bot_reg [0:1];

    logic [PX_W-1:0]    lb0_rd;
    logic [PX_W-1:0]    lb1_rd;
    logic [PX_W-1:0]    win_px [0:8];
    logic [27*PIX_W-1:0] win_next;

    logic px_acc;
    logic win_acc;
    logic col_last;
    logic row_last;
    logic win_en;

    logic                win_valid_reg;
    logic [27*PIX_W-1:0] win_data_reg;
    logic                win_last_reg;
    logic                frame_done_reg;

    assign px_ready_o   = ((state_reg == ST_IDLE) || (state_reg == ST_RUN)) &&
                          (!win_valid_reg || win_ready_i);
    assign px_acc       = px_valid_i && px_ready_o;
    assign win_acc      = win_valid_reg && win_ready_i;
    assign col_last     = (col_reg == COL_W'(IMG_WIDTH - 1));
    assign row_last     = (row_reg == ROW_W'(IMG_HEIGHT - 1));
    assign win_en       = (row_reg >= ROW_W'(2)) && (col_reg >= COL_W'(2));

    assign lb0_rd       = linebuf0_mem[col_reg];
    assign lb1_rd       = linebuf1_mem[col_reg];

    assign win_valid_o  = win_valid_reg;
    assign win_data_o   = win_data_reg;
    assign win_last_o   = win_last_reg;
    assign frame_done_o = frame_done_reg;

    // Gather the nine pixels of the window ending at the incoming pixel, k_0..k_8
    always_comb begin
        win_px[0] = top_reg[0];
        win_px[1] = top_reg[1];
        win_px[2] = lb1_rd;
        win_px[3] = mid_reg[0];
        win_px[4] = mid_reg[1];
        win_px[5] = lb0_rd;
        win_px[6] = bot_reg[0];
        win_px[7] = bot_reg[1];
        win_px[8] = px_data_i;
    end

    // Scatter each pixel's channel bytes into the channel-major window layout, k_0 at the MSB
    genvar gi, gk;
    generate
        for (gi = 0; gi < 3; gi++) begin : g_chan
            for (gk = 0; gk < 9; gk++) begin : g_tap
                assign win_next[gi*CH_W + (8-gk)*PIX_W +: PIX_W] = win_px[gk][gi*PIX_W +: PIX_W];
            end
        end
    endgenerate

    // Line buffers and column shift registers advance on every accepted pixel; contents need no reset
    always_ff @(posedge clk_i) begin
        if (px_acc) begin
            linebuf1_mem[col_reg] <= lb0_rd;
            linebuf0_mem[col_reg] <= px_data_i;
            top_reg[0] <= top_reg[1];
            top_reg[1] <= lb1_rd;
            mid_reg[0] <= mid_reg[1];
            mid_reg[1] <= lb0_rd;
            bot_reg[0] <= bot_reg[1];
            bot_reg[1] <= px_data_i;
        end
    end

    // Frame FSM and raster position counters
    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= ST_IDLE;
            col_reg   <= '0;
            row_reg   <= '0;
        end else begin
            case (state_reg)
                ST_IDLE, ST_RUN: begin
                    if (px_acc) begin
                        state_reg <= ST_RUN;
                        if (col_last) begin
                            col_reg <= '0;
                            if (row_last) begin
                                row_reg   <= '0;
                                state_reg <= ST_FLUSH;
                            end else begin
                                row_reg <= row_reg + 1'b1;
                            end
                        end else begin
                            col_reg <= col_reg + 1'b1;
                        end
                    end
                end
                ST_FLUSH: begin
                    if (win_acc && win_last_reg) begin
                        state_reg <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    state_reg <= ST_IDLE;
                    col_reg   <= '0;
                    row_reg   <= '0;
                end
                default: state_reg <= ST_IDLE;
            endcase
        end
    end

    // Output register: load a new window, or drop valid once the held window is taken
    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            win_valid_reg <= 1'b0;
            win_data_reg  <= '0;
            win_last_reg  <= 1'b0;
        end else if (px_acc && win_en) begin
            win_valid_reg <= 1'b1;
            win_data_reg  <= win_next;
            win_last_reg  <= row_last && col_last;
        end else if (win_acc) begin
            win_valid_reg <= 1'b0;
            win_last_reg  <= 1'b0;
        end
    end

    // One-cycle completion pulse in the cycle after the final window is taken
    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            frame_done_reg <= 1'b0;
        end else begin
            frame_done_reg <= (state_reg == ST_FLUSH) && win_acc && win_last_reg;
        end
    end

endmodule

// File: tb/tb_rgb_window_feeder.sv
// Bench for rgb_window_feeder: a 4x4 and a 32x32 instance share one stimulus
// driver; a scoreboard queue filled from an image-array reference model is
// drained by an independent monitor on every window handshake.
module tb_rgb_window_feeder;

    typedef struct {
        logic [215:0] data;
        logic         last;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         px_valid;
    logic [23:0]  px_data;
    logic         win_ready;
    logic         sel;

    logic         px_valid4, px_valid32;
    logic         px_ready4, px_ready32, px_ready_m;
    logic         win_valid4, win_valid32, win_valid_m;
    logic [215:0] win_data4, win_data32, win_data_m;
    logic         win_last4, win_last32, win_last_m;
    logic         done4, done32, done_m;

    int           W, H;
    logic [23:0]  img [0:31][0:31];
    exp_t         exp_q [$];
    int           cyc_q [$];
    int           cyc = 0;
    int           checks = 0;
    int           errors = 0;
    int           ready_mode = 1;
    int           done_cnt = 0;
    int           win_cnt = 0;
    logic [215:0] first_win;
    bit           aborted = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    assign px_valid4   = px_valid & ~sel;
    assign px_valid32  = px_valid & sel;
    assign px_ready_m  = sel ? px_ready32  : px_ready4;
    assign win_valid_m = sel ? win_valid32 : win_valid4;
    assign win_data_m  = sel ? win_data32  : win_data4;
    assign win_last_m  = sel ? win_last32  : win_last4;
    assign done_m      = sel ? done32      : done4;

    rgb_window_feeder #(.IMG_WIDTH(4), .IMG_HEIGHT(4), .PIX_W(8)) u_dut4 (
        .clk_i(clk), .rst_n(rst_n),
        .px_valid_i(px_valid4), .px_ready_o(px_ready4), .px_data_i(px_data),
        .win_valid_o(win_valid4), .win_ready_i(win_ready), .win_data_o(win_data4),
        .win_last_o(win_last4), .frame_done_o(done4)
    );

    rgb_window_feeder #(.IMG_WIDTH(32), .IMG_HEIGHT(32), .PIX_W(8)) u_dut32 (
        .clk_i(clk), .rst_n(rst_n),
        .px_valid_i(px_valid32), .px_ready_o(px_ready32), .px_data_i(px_data),
        .win_valid_o(win_valid32), .win_ready_i(win_ready), .win_data_o(win_data32),
        .win_last_o(win_last32), .frame_done_o(done32)
    );

    task automatic check(input string name, input logic [215:0] act, input logic [215:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, req);
        end
    endtask

    // Reference window: the 3x3 neighbourhood ending at (r,c), row-major, per channel
    function automatic logic [215:0] ref_win(input int r, input int c);
        logic [215:0] w;
        logic [23:0]  p;
        w = '0;
        for (int ch = 0; ch < 3; ch++) begin
            for (int k = 0; k < 9; k++) begin
                p = img[r - 2 + k / 3][c - 2 + k % 3];
                w[ch*72 + (8-k)*8 +: 8] = p[ch*8 +: 8];
            end
        end
        return w;
    endfunction

    task automatic build_img(input int base, input bit rnd);
        int p;
        logic [31:0] rv;
        for (int r = 0; r < H; r++) begin
            for (int c = 0; c < W; c++) begin
                p = r * W + c + base;
                rv = $urandom();
                img[r][c] = rnd ? rv[23:0] : {8'(p), 8'(p + 16), 8'(p + 32)};
            end
        end
    endtask

    // Presents one pixel; on acceptance records the expected window and its due cycle
    task automatic send_px(input int r, input int c, input bit gaps);
        int n;
        exp_t e;
        if (gaps) begin
            while ($urandom_range(1) == 1) begin
                px_valid = 1'b0;
                @(posedge clk);
                #1;
            end
        end
        px_valid = 1'b1;
        px_data  = img[r][c];
        n = 0;
        forever begin
            @(negedge clk);
            if (px_ready_m) break;
            n++;
            if (n > 500) begin
                checks++;
                errors++;
                aborted = 1;
                $display("FAIL px_accept_timeout: pixel (%0d,%0d) not accepted after %0d cycles, required within 500", r, c, n);
                px_valid = 1'b0;
                return;
            end
        end
        if (r >= 2 && c >= 2) begin
            e.data = ref_win(r, c);
            e.last = (r == H - 1) && (c == W - 1);
            exp_q.push_back(e);
            cyc_q.push_back(cyc + 1);
        end
        @(posedge clk);
        #1;
        px_valid = 1'b0;
    endtask

    task automatic run_frame(input int base, input bit rnd, input bit hold);
        int d0;
        int n;
        logic [215:0] snap;
        build_img(base, rnd);
        ready_mode = hold ? 0 : (rnd ? 2 : 1);
        d0 = done_cnt;
        for (int r = 0; r < H && !aborted; r++) begin
            for (int c = 0; c < W && !aborted; c++) begin
                send_px(r, c, rnd);
                if (hold && r == 2 && c == 2) begin
                    snap = win_data_m;
                    for (int i = 0; i < 5; i++) begin
                        @(negedge clk);
                        check("hold_px_ready", px_ready_m, 0);
                        check("hold_win_data", win_data_m, snap);
                    end
                    ready_mode = 1;
                end
            end
        end
        n = 0;
        while (done_cnt == d0 && n < 2000) begin
            @(negedge clk);
            n++;
        end
        if (done_cnt == d0) begin
            checks++;
            errors++;
            $display("FAIL frame_done_timeout: no frame_done_o after %0d cycles, required one pulse", n);
        end
    endtask

    // Win-ready driver
    initial begin
        win_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            case (ready_mode)
                0:       win_ready = 1'b0;
                2:       win_ready = 1'($urandom_range(1));
                default: win_ready = 1'b1;
            endcase
        end
    end

    // Monitor: scoreboard pop on handshake, latency, hold stability, completion pulse
    initial begin : monitor
        logic         prev_v, prev_acc, prev_l, v, acc, done_due;
        logic [215:0] prev_d;
        exp_t         e;
        int           due;
        prev_v = 0; prev_acc = 0; prev_l = 0; prev_d = '0; done_due = 0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                prev_v = 0; prev_acc = 0; done_due = 0; win_cnt = 0;
                continue;
            end
            v   = win_valid_m;
            acc = v && win_ready;
            if (done_due || done_m) begin
                check("frame_done", done_m, done_due);
                if (done_m) done_cnt++;
            end
            done_due = 0;
            if (prev_v && !prev_acc) begin
                check("held_valid", v, 1);
                if (v) begin
                    check("held_data", win_data_m, prev_d);
                    check("held_last", win_last_m, prev_l);
                end
            end else if (v) begin
                if (cyc_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL spurious_window: got window %h, expected none", win_data_m);
                end else begin
                    due = cyc_q.pop_front();
                    check("window_latency_cycle", 216'(cyc), 216'(due));
                end
            end
            if (acc) begin
                if (exp_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL unexpected_window: got %h, expected no window", win_data_m);
                end else begin
                    e = exp_q.pop_front();
                    check("window_data", win_data_m, e.data);
                    check("window_last", win_last_m, e.last);
                    $display("window %0d accepted: data %h last %0d", win_cnt, win_data_m, win_last_m);
                end
                if (win_cnt == 0) first_win = win_data_m;
                win_cnt++;
                if (win_last_m) begin
                    check("windows_per_frame", 216'(win_cnt), 216'((W - 2) * (H - 2)));
                    win_cnt  = 0;
                    done_due = 1;
                end
            end
            prev_v = v; prev_acc = acc; prev_d = win_data_m; prev_l = win_last_m;
        end
    end

    initial begin
        rst_n = 1'b0; sel = 1'b0; px_valid = 1'b0; px_data = '0;
        W = 4; H = 4;
        repeat (3) @(negedge clk);
        check("reset_win_valid", win_valid_m, 0);
        check("reset_win_data", win_data_m, 0);
        check("reset_win_last", win_last_m, 0);
        check("reset_frame_done", done_m, 0);
        check("reset_px_ready", px_ready_m, 1);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // 4x4 streaming frame, ready always high
        run_frame(0, 0, 0);
        check("frame1_first_window", first_win,
              216'h00010204050608090a_101112141516_18191a_202122242526_28292a);

        // 4x4 frame with 5 cycles of backpressure on window 1
        run_frame(0, 0, 1);
        check("hold_frame_first_window", first_win,
              216'h00010204050608090a_101112141516_18191a_202122242526_28292a);

        // 32x32 random data with random gaps on both sides
        sel = 1'b1; W = 32; H = 32;
        run_frame(0, 1, 0);
        sel = 1'b0; W = 4; H = 4;
        @(posedge clk); #1;

        // Asynchronous reset mid-frame with a window pending
        build_img(0, 0);
        ready_mode = 0;
        for (int i = 0; i < 11; i++) send_px(i / 4, i % 4, 0);
        check("pre_reset_win_valid", win_valid_m, 1);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_reset_win_valid", win_valid_m, 0);
        check("async_reset_win_data", win_data_m, 0);
        check("async_reset_win_last", win_last_m, 0);
        check("async_reset_frame_done", done_m, 0);
        exp_q.delete();
        cyc_q.delete();
        repeat (2) @(negedge clk);
        check("reset_held_frame_done", done_m, 0);
        rst_n = 1'b1;
        @(posedge clk); #1;
        run_frame(0, 0, 0);
        check("post_reset_first_window", first_win,
              216'h00010204050608090a_101112141516_18191a_202122242526_28292a);

        // Two frames back to back; second must not see first frame's rows
        run_frame(0, 0, 0);
        run_frame(100, 0, 0);
        check("frame2_first_window_R", 216'(first_win[215:144]), 216'(72'h646566_68696a_6c6d6e));

        repeat (3) @(negedge clk);
        check("scoreboard_empty", 216'(exp_q.size()), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
